pwm_capture: RTL and testbench

// - Memory-mapped PWM measurement peripheral; the reader for the SoC PWM generator.
// - Samples an external pwm_in and reports the period and high time of the last complete cycle, in clk cycles.
// - Sits on the CPU data bus beside GPIO/PWM. In system test, pwm_out loops back to pwm_in to self-check duty programming.

---
 rtl/pwm_capture_pkg.sv | 15 +
 rtl/pwm_capture_sync_edge.sv | 27 ++
 rtl/pwm_capture.sv | 105 ++++++++++
 tb/tb_pwm_capture.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: register map, bit indices and FSM encodings for the PWM capture peripheral
package pwm_capture_pkg;
    localparam logic [3:0] PWMCAP_CTRL   = 4'h0;
    localparam logic [3:0] PWMCAP_STATUS = 4'h4;
    localparam logic [3:0] PWMCAP_PERIOD = 4'h8;
    localparam logic [3:0] PWMCAP_HIGH   = 4'hC;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int STAT_VALID  = 0;
    localparam int STAT_OVF    = 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MEAS = 1'b1;
endpackage

// File: rtl/pwm_capture_sync_edge.sv
// sync_edge: synchronizer chain plus delay flop, giving a clean level and a one-cycle rise pulse
// Ports: clk, rst (async, active-high), d (async input), s (synchronized level), rise (s & ~s_d)
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic s,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   s_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            s_d  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
            s_d  <= sync[SYNC_STAGES-1];
        end
    end

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~s_d;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: memory-mapped PWM period/high-time measurement peripheral
// Ports: clk, rst (async, active-high); bus sel/we/addr/wdata/rdata (rdata registered);
//        pwm_in (async PWM input); irq (level, irq_en & valid)
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        pwm_in,
    output logic        irq
);
    logic             s;
    logic             rise;
    logic [0:0]       state;
    logic             en;
    logic             irq_en;
    logic             valid;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] high_r;
    logic [31:0]      rd_mux;
    logic             ctrl_wr;
    logic             stat_wr;
    logic             capture;
    logic             overflow;
    logic             unused_wdata;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (pwm_in),
        .s    (s),
        .rise (rise)
    );

    assign ctrl_wr      = sel & we & (addr == PWMCAP_CTRL);
    assign stat_wr      = sel & we & (addr == PWMCAP_STATUS);
    assign capture      = (state == MEAS) & en & rise;
    assign overflow     = (state == MEAS) & en & ~rise & (cnt == '1);
    assign irq          = irq_en & valid;
    assign unused_wdata = ^wdata[31:2];

    assign rd_mux = (addr == PWMCAP_CTRL)   ? {30'd0, irq_en, en} :
                    (addr == PWMCAP_STATUS) ? {30'd0, ovf, valid} :
                    (addr == PWMCAP_PERIOD) ? 32'(period_r) :
                    (addr == PWMCAP_HIGH)   ? 32'(high_r) : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata    <= '0;
            en       <= 1'b0;
            irq_en   <= 1'b0;
            valid    <= 1'b0;
            ovf      <= 1'b0;
            period_r <= '0;
            high_r   <= '0;
            state    <= IDLE;
            cnt      <= '0;
            hcnt     <= '0;
        end else begin
            if (sel & ~we)
                rdata <= rd_mux;
            if (ctrl_wr) begin
                en     <= wdata[CTRL_EN];
                irq_en <= wdata[CTRL_IRQ_EN];
            end
            // Hardware set beats a software clear landing in the same cycle
            valid <= capture  | (valid & ~(stat_wr & wdata[STAT_VALID]));
            ovf   <= overflow | (ovf   & ~(stat_wr & wdata[STAT_OVF]));
            // Both results load on the same edge so software always reads a matched pair
            if (capture) begin
                period_r <= cnt + 1'b1;
                high_r   <= hcnt;
            end
            // The rise cycle itself is high, so a fresh period starts with hcnt=1
            if (state == IDLE) begin
                if (en & rise) begin
                    state <= MEAS;
                    cnt   <= '0;
                    hcnt  <= CNT_W'(1);
                end
            end else if (~en | overflow) begin
                state <= IDLE;
                cnt   <= '0;
                hcnt  <= '0;
            end else if (rise) begin
                cnt  <= '0;
                hcnt <= CNT_W'(1);
            end else begin
                cnt  <= cnt + 1'b1;
                hcnt <= hcnt + CNT_W'(s && (hcnt != '1));
            end
        end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed self-checking bench for pwm_capture (CNT_W=8 to reach overflow quickly)
module tb_pwm_capture;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        pwm_in = 1'b0;
    logic        irq;
    int          checks = 0;
    int          failures = 0;

    pwm_capture #(.CNT_W(8), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .sel    (sel),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .pwm_in (pwm_in),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0; wdata = 32'd0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        sel = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        d = rdata;
        sel = 1'b0;
    endtask

    task automatic drive_period(input int period, input int high);
        for (int i = 0; i < period; i++) begin
            pwm_in = (i < high);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        checks++;
        if (rdata !== 32'd0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_out rdata=%0h irq=%0b expected 0/0", rdata, irq);
        end
        @(negedge clk);
        rst = 1'b0;
        bus_read(4'h0, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL reset_ctrl got=%0h exp=0", d); end
        bus_read(4'h4, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL reset_status got=%0h exp=0", d); end
        bus_read(4'h8, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL reset_period got=%0h exp=0", d); end
        bus_read(4'hC, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL reset_high got=%0h exp=0", d); end
    endtask

    task automatic test_basic;
        logic [31:0] d;
        bus_write(4'h0, 32'd3);
        bus_read(4'h0, d); checks++;
        if (d !== 32'd3) begin failures++; $display("FAIL basic_ctrl got=%0h exp=3", d); end
        repeat (4) drive_period(10, 3);
        bus_read(4'h8, d); checks++;
        if (d !== 32'd10) begin failures++; $display("FAIL basic_period got=%0d exp=10", d); end
        bus_read(4'hC, d); checks++;
        if (d !== 32'd3) begin failures++; $display("FAIL basic_high got=%0d exp=3", d); end
        bus_read(4'h4, d); checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL basic_status got=%0h exp=1", d); end
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL basic_irq_set got=%0b exp=1", irq); end
        bus_write(4'h4, 32'd1);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL basic_irq_clr got=%0b exp=0", irq); end
        bus_read(4'h4, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL basic_w1c got=%0h exp=0", d); end
        bus_write(4'h8, 32'hFF);
        bus_read(4'h8, d); checks++;
        if (d !== 32'd10) begin failures++; $display("FAIL basic_ro_period got=%0d exp=10", d); end
        bus_read(4'h2, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL basic_unmapped got=%0h exp=0", d); end
    endtask

    task automatic test_duty_sweep;
        logic [31:0] d;
        int highs[3] = '{1, 10, 19};
        foreach (highs[k]) begin
            repeat (3) drive_period(20, highs[k]);
            bus_read(4'h8, d); checks++;
            if (d !== 32'd20) begin failures++; $display("FAIL sweep_period h=%0d got=%0d exp=20", highs[k], d); end
            bus_read(4'hC, d); checks++;
            if (d !== 32'(highs[k])) begin failures++; $display("FAIL sweep_high got=%0d exp=%0d", d, highs[k]); end
        end
    endtask

    task automatic test_clear_race;
        logic [31:0] d;
        bus_write(4'h4, 32'd3);
        // Rise reaches the FSM on the third rising edge after pwm_in goes high; W1C targets that edge.
        pwm_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus_write(4'h4, 32'd1);
        pwm_in = 1'b0;
        bus_read(4'h4, d); checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL race_valid got=%0h exp=1", d); end
        bus_write(4'h4, 32'd1);
        bus_read(4'h4, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL race_w1c got=%0h exp=0", d); end
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        repeat (2) drive_period(12, 5);
        pwm_in = 1'b1;
        repeat (300) @(negedge clk);
        bus_read(4'h4, d); checks++;
        if (d !== 32'd3) begin failures++; $display("FAIL ovf_status got=%0h exp=3", d); end
        bus_read(4'h8, d); checks++;
        if (d !== 32'd12) begin failures++; $display("FAIL ovf_period got=%0d exp=12", d); end
        bus_read(4'hC, d); checks++;
        if (d !== 32'd5) begin failures++; $display("FAIL ovf_high got=%0d exp=5", d); end
        pwm_in = 1'b0;
        repeat (4) @(negedge clk);
        bus_write(4'h4, 32'd3);
        drive_period(15, 6);
        // FSM was idle, so that rise only armed it; the read adds one low cycle (period 16).
        bus_read(4'h4, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL ovf_rearm got=%0h exp=0", d); end
        repeat (2) drive_period(15, 6);
        bus_read(4'h8, d); checks++;
        if (d !== 32'd15) begin failures++; $display("FAIL ovf_after_period got=%0d exp=15", d); end
        bus_read(4'hC, d); checks++;
        if (d !== 32'd6) begin failures++; $display("FAIL ovf_after_high got=%0d exp=6", d); end
    endtask

    task automatic test_disable;
        logic [31:0] d;
        pwm_in = 1'b1;
        repeat (5) @(negedge clk);
        bus_write(4'h0, 32'd2);
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        bus_write(4'h4, 32'd3);
        bus_write(4'h0, 32'd3);
        // First period after enable: 7 high, then 13 low with a STATUS read inside the low phase.
        pwm_in = 1'b1;
        repeat (7) @(negedge clk);
        pwm_in = 1'b0;
        bus_read(4'h4, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL dis_first_rise got=%0h exp=0", d); end
        repeat (12) @(negedge clk);
        drive_period(20, 7);
        sel = 1'b1; we = 1'b0; addr = 4'h8;
        #1 checks++;
        if (rdata !== 32'd0) begin failures++; $display("FAIL dis_rd_early got=%0d exp=0", rdata); end
        @(negedge clk);
        sel = 1'b0;
        checks++;
        if (rdata !== 32'd20) begin failures++; $display("FAIL dis_period got=%0d exp=20", rdata); end
        @(negedge clk);
        checks++;
        if (rdata !== 32'd20) begin failures++; $display("FAIL dis_rd_hold got=%0d exp=20", rdata); end
        bus_read(4'hC, d); checks++;
        if (d !== 32'd7) begin failures++; $display("FAIL dis_high got=%0d exp=7", d); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        repeat (3) drive_period(10, 3);
        bus_read(4'h8, d); checks++;
        if (d !== 32'd10 || irq !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre period=%0d irq=%0b exp=10/1", d, irq);
        end
        pwm_in = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 checks++;
        if (rdata !== 32'd0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async rdata=%0h irq=%0b exp=0/0", rdata, irq);
        end
        @(negedge clk);
        rst = 1'b0;
        pwm_in = 1'b0;
        bus_read(4'h0, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL rstmid_ctrl got=%0h exp=0", d); end
        bus_read(4'h4, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL rstmid_status got=%0h exp=0", d); end
        bus_read(4'h8, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL rstmid_period got=%0h exp=0", d); end
        bus_read(4'hC, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL rstmid_high got=%0h exp=0", d); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_basic;
        test_duty_sweep;
        test_clear_race;
        test_overflow;
        test_disable;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
